// File: rtl/csa_accumulator.sv
// Carry-save accumulator: reduces a group of W-bit operands into a (sum, carry) vector pair
// and hands the pair to a downstream carry-propagate stage. Define CSA_OVF_DETECT_EN to build the sticky overflow flag.
module csa_accumulator #(
  parameter int W     = 4,
  parameter int COUNT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic [W-1:0] c,
  output logic         ovf
);

  localparam int CW = $clog2(COUNT + 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(COUNT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [W-1:0]  r_s;
  logic [W-1:0]  r_c;
  logic [CW-1:0] r_cnt;

  logic          w_accept;
  logic          w_close;
  logic [W-1:0]  w_maj;
  logic [W-1:0]  w_c_next;
  logic [CW-1:0] w_cnt_next;

  assign in_ready  = (r_state != ST_DONE);
  assign out_valid = (r_state == ST_DONE);
  assign s         = r_s;
  assign c         = r_c;

  assign w_accept   = in_valid && in_ready;
  // The majority's MSB would carry into weight 2^W; the shift drops it (mod 2^W).
  assign w_maj      = (r_s & r_c) | (r_s & x) | (r_c & x);
  assign w_c_next   = w_maj << 1;
  assign w_cnt_next = r_cnt + CW'(1);
  assign w_close    = in_last || (w_cnt_next == COUNT_MAX);

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_c     <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ACC: begin
          if (w_accept) begin
            r_s     <= r_s ^ r_c ^ x;
            r_c     <= w_c_next;
            r_cnt   <= w_cnt_next;
            r_state <= w_close ? ST_DONE : ST_ACC;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_s     <= '0;
            r_c     <= '0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef CSA_OVF_DETECT_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == ST_DONE) begin
      if (out_ready) r_ovf <= 1'b0;
    end else if (w_accept && w_maj[W-1]) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_csa_accumulator.sv
// Self-checking bench for csa_accumulator (W=4, COUNT=4): directed scenarios plus random traffic
// against an arithmetic reference model (running group sum mod 16, operand count, pending result).
module tb_csa_accumulator;

  localparam int W     = 4;
  localparam int COUNT = 4;

`ifdef CSA_OVF_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] s;
  logic [W-1:0] c;
  logic         ovf;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference model: group sum, operand count, result-pending flag, overflow occurrence.
  logic [W-1:0] m_sum;
  int           m_cnt;
  bit           m_pending;
  bit           m_ovf;
  logic [W-1:0] m_s, m_c;

  always #5 clk = ~clk;

  csa_accumulator #(.W(W), .COUNT(COUNT)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .c        (c),
    .ovf      (ovf)
  );

  task automatic model_clear();
    m_sum = '0; m_cnt = 0; m_pending = 0; m_ovf = 0; m_s = '0; m_c = '0;
  endtask

  // One clock: drive inputs, advance the model on the edge, sample #1 after the edge.
  task automatic drive(input logic v, input logic [W-1:0] xv, input logic last, input logic ordy);
    logic [W-1:0] maj;
    in_valid = v; x = xv; in_last = last; out_ready = ordy;
    @(posedge clk);
    if (m_pending) begin
      if (ordy) model_clear();
    end else if (v) begin
      maj = (m_s & m_c) | (m_s & xv) | (m_c & xv);
      if (maj[W-1]) m_ovf = 1;
      m_s   = m_s ^ m_c ^ xv;
      m_c   = maj << 1;
      m_sum = m_sum + xv;
      m_cnt++;
      if (last || m_cnt == COUNT) m_pending = 1;
    end
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1; in_valid = 1'b1; x = 4'hF; in_last = 1'b1; out_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset(2);
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    chk_cnt++; if (s !== 4'h0 || c !== 4'h0) $display("FAIL reset_sc got=%h/%h exp=0/0", s, c); else pass_cnt++;
    chk_cnt++; if (ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", ovf); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    drive(0, 4'h0, 0, 0);
    chk_cnt++; if (s !== 4'h0 || c !== 4'h0) $display("FAIL reset_no_accept got=%h/%h exp=0/0", s, c); else pass_cnt++;
  endtask

  task automatic test_full_group();
    logic [W-1:0] xs [4] = '{4'h3, 4'h5, 4'h6, 4'h1};
    logic [W-1:0] es [4] = '{4'h3, 4'h6, 4'h2, 4'hF};
    logic [W-1:0] ec [4] = '{4'h0, 4'h2, 4'hC, 4'h0};
    for (int i = 0; i < 4; i++) begin
      drive(1, xs[i], 0, 0);
      chk_cnt++;
      if (s !== es[i] || c !== ec[i]) $display("FAIL full_sc%0d got=%h/%h exp=%h/%h", i, s, c, es[i], ec[i]);
      else pass_cnt++;
      chk_cnt++;
      if (out_valid !== (i == 3)) $display("FAIL full_valid%0d got=%b exp=%b", i, out_valid, (i == 3));
      else pass_cnt++;
    end
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got=%b exp=0", in_ready); else pass_cnt++;
    drive(0, 4'h0, 0, 1);
    chk_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || s !== 4'h0 || c !== 4'h0)
      $display("FAIL full_consume got=v%b r%b %h/%h exp=v0 r1 0/0", out_valid, in_ready, s, c);
    else pass_cnt++;
  endtask

  task automatic test_early_close();
    logic [W-1:0] sum;
    drive(1, 4'h7, 0, 0);
    drive(1, 4'h1, 1, 0);
    chk_cnt++;
    if (out_valid !== 1'b1 || s !== 4'h6 || c !== 4'h2)
      $display("FAIL early_result got=v%b %h/%h exp=v1 6/2", out_valid, s, c);
    else pass_cnt++;
    drive(0, 4'h0, 0, 1);
    drive(0, 4'h0, 0, 0);
    // Count must have restarted: three operands leave the group open, the fourth closes it.
    for (int i = 0; i < 4; i++) begin
      drive(1, 4'h2, 0, 0);
      chk_cnt++;
      if (out_valid !== (i == 3)) $display("FAIL early_count%0d got=%b exp=%b", i, out_valid, (i == 3));
      else pass_cnt++;
    end
    sum = s + c;
    chk_cnt++; if (sum !== 4'h8) $display("FAIL early_count_sum got=%h exp=8", sum); else pass_cnt++;
    drive(0, 4'h0, 0, 1);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] hs, hc, sum;
    drive(0, 4'h0, 0, 0);
    drive(1, 4'h1, 0, 0); drive(1, 4'h2, 0, 0); drive(1, 4'h3, 0, 0); drive(1, 4'h4, 0, 0);
    hs = s; hc = c; sum = s + c;
    chk_cnt++; if (sum !== 4'hA) $display("FAIL bp_sum got=%h exp=a", sum); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'($urandom_range(0, 15)), 0, 0);
      chk_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || s !== hs || c !== hc)
        $display("FAIL bp_hold%0d got=v%b r%b %h/%h exp=v1 r0 %h/%h", i, out_valid, in_ready, s, c, hs, hc);
      else pass_cnt++;
    end
    drive(1, 4'h9, 0, 1);
    chk_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || s !== 4'h0 || c !== 4'h0)
      $display("FAIL bp_release got=v%b r%b %h/%h exp=v0 r1 0/0", out_valid, in_ready, s, c);
    else pass_cnt++;
    drive(1, 4'h9, 0, 0);
    chk_cnt++;
    if (s !== 4'h9 || c !== 4'h0) $display("FAIL bp_fresh got=%h/%h exp=9/0", s, c); else pass_cnt++;
    drive(1, 4'h0, 1, 0);
    drive(0, 4'h0, 0, 1);
  endtask

  task automatic test_overflow();
    drive(0, 4'h0, 0, 0);
    drive(1, 4'h8, 0, 0);
    drive(1, 4'h8, 1, 0);
    chk_cnt++;
    if (out_valid !== 1'b1 || s !== 4'h0 || c !== 4'h0)
      $display("FAIL ovf_sc got=v%b %h/%h exp=v1 0/0", out_valid, s, c);
    else pass_cnt++;
    chk_cnt++; if (ovf !== OVF_EN) $display("FAIL ovf_flag got=%b exp=%b", ovf, OVF_EN); else pass_cnt++;
    drive(0, 4'h0, 0, 1);
    chk_cnt++; if (ovf !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", ovf); else pass_cnt++;
  endtask

  task automatic test_reset_mid_group();
    logic [W-1:0] sum;
    drive(1, 4'h3, 0, 0);
    drive(1, 4'h5, 0, 0);
    do_reset(1);
    for (int i = 0; i < 4; i++) drive(1, 4'h1, 0, 0);
    sum = s + c;
    chk_cnt++;
    if (out_valid !== 1'b1 || sum !== 4'h4) $display("FAIL midrst got=v%b sum=%h exp=v1 sum=4", out_valid, sum);
    else pass_cnt++;
    drive(0, 4'h0, 0, 1);
  endtask

  task automatic test_random();
    logic [W-1:0] sum;
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0));
      sum = s + c;
      chk_cnt++;
      if (in_ready !== !m_pending || out_valid !== m_pending || sum !== m_sum || ovf !== (OVF_EN & m_ovf)) begin
        if (errs < 10)
          $display("FAIL rand%0d got=r%b v%b sum=%h ovf=%b exp=r%b v%b sum=%h ovf=%b", i, in_ready, out_valid,
                   sum, ovf, !m_pending, m_pending, m_sum, OVF_EN & m_ovf);
        errs++;
      end else pass_cnt++;
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_full_group();
    test_early_close();
    test_backpressure();
    test_overflow();
    test_reset_mid_group();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/csa_accumulator.md
Name: csa_accumulator

Overview:
- Sequential carry-save accumulator that sits directly upstream of the team's W-bit carry-propagate stage.
- Accepts a stream of W-bit operands over a valid/ready handshake and reduces them without carry propagation, holding a sum vector and a carry vector.
- Once the operand group is finished, presents the (s, c) pair to the downstream stage under a valid/ready handshake.
- All arithmetic is modulo 2^W.

Parameters:
- W, 4, operand, sum-vector and carry-vector width in bits (W >= 2).
- COUNT, 4, maximum operands per group (COUNT >= 1); the group closes automatically on the COUNT-th accepted operand.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand x valid.
- in_ready  output  1  block can accept x this cycle.
- x  input  W  operand.
- in_last  input  1  qualifies x as the final operand of the group (early close).
- out_valid  output  1  s/c pair valid.
- out_ready  input  1  downstream accepts the s/c pair.
- s  output  W  sum vector.
- c  output  W  carry vector, already shifted into its weight position.
- ovf  output  1  sticky overflow flag for the group (see Optional Feature).

Behaviour:
- Reset: synchronous, active-high, sampled on the rising edge of clk.
  - Clears s, c, the operand count and ovf to 0 and sets the state to IDLE.
  - out_valid = 0; in_ready = 1 from the first cycle after rst deasserts.
  - Reset mid-group or mid-DONE discards all accumulated data; no output is produced.
- States:
  - IDLE: s = 0, c = 0, count = 0, in_ready = 1, out_valid = 0.
  - ACC: at least one operand taken, in_ready = 1, out_valid = 0.
  - DONE: in_ready = 0, out_valid = 1, s/c/ovf held stable.
- Accept: an operand is accepted when in_valid && in_ready at the clock edge.
  - s_next = s ^ c ^ x.
  - c_next = ((s&c) | (s&x) | (c&x)) << 1, truncated to W bits; the bit shifted out of position W-1 is discarded.
  - count_next = count + 1. The count register is wide enough to hold COUNT.
- Transitions:
  - IDLE -> ACC on accept when the group does not close.
  - IDLE -> DONE on accept when the group closes.
  - ACC -> ACC on accept when the group does not close.
  - ACC -> DONE on accept when the group closes.
  - The group closes when in_last = 1 or count_next == COUNT. With COUNT = 1, every operand closes its group.
  - DONE -> IDLE when out_ready = 1. On that edge s, c, count and ovf are cleared.
- Latency:
  - out_valid rises on the clock edge that accepts the closing operand, i.e. the cycle after that operand is presented.
  - Minimum one idle cycle (IDLE, with in_ready = 1) between out_valid dropping and the next group's first accept. No operand is accepted in the cycle the result is consumed.
- Invariant: (s + c) mod 2^W equals the sum of all accepted operands mod 2^W.
- No accept in ACC/IDLE: all state holds. in_last without in_valid is ignored.
- DONE with out_ready = 0: s, c, out_valid and ovf stay stable indefinitely; in_valid is ignored.

Optional Feature:
- Macro: CSA_OVF_DETECT_EN.
- Defined: ovf is a sticky register. It is set on any accept whose majority term has bit W-1 = 1, i.e. a carry is discarded during the shift. It is cleared by rst and on DONE -> IDLE, and is valid alongside out_valid.
- Not defined: no overflow logic is instantiated and ovf is tied to 0. All other behaviour is identical.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with in_valid = 1 -> out_valid = 0, s = 0, c = 0, ovf = 0; after release in_ready = 1, no accept occurred during reset.
- Full group (W = 4, COUNT = 4): accept x = 3, 5, 6, 1 on consecutive cycles.
  - Internal (s, c) progression: (3, 0), (6, 2), (2, 0xC), (0xF, 0).
  - Next cycle: out_valid = 1, s = 0xF, c = 0x0; in_ready = 0.
- Early close: accept x = 7, then x = 1 with in_last = 1 -> out_valid = 1, s = 0x6, c = 0x2 (sum 8); count resets after consume.
- Backpressure: complete a group with out_ready = 0 for 5 cycles and in_valid = 1 throughout -> s/c/out_valid stable, no operand absorbed; out_ready = 1 -> out_valid = 0 next cycle, in_ready = 1, next group starts from s = c = 0.
- Overflow (CSA_OVF_DETECT_EN defined): accept x = 8, 8 with in_last on the second -> s = 0x0, c = 0x0, ovf = 1; repeat without the macro -> ovf = 0.
- Reset mid-group: accept 3, 5, assert rst for one cycle, then accept 1, 1, 1, 1 -> s + c (mod 16) = 4, no stale contribution.
